// File: rtl/montgomery_pkg.sv
// Shared types and helpers for the Montgomery constant feeder.
package montgomery_pkg;

    // Which per-modulus constant a host write targets.
    typedef enum logic {
        CONST_K = 1'b0,
        CONST_N = 1'b1
    } const_sel_t;

    // Width of a block index; at least one bit so a single-block constant still has a pointer.
    function automatic int block_idx_w(input int num_blocks);
        int w;
        w = 1;
        while ((1 << w) < num_blocks) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : montgomery_pkg

// File: rtl/constant_block_channel.sv
// One constant channel: block memory, host write pointer, reader index and loaded flag.
module constant_block_channel
    import montgomery_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en,
    input  logic [REGISTER_SIZE-1:0] wr_data,
    input  logic                     rewind,
    input  logic                     consumed,
    output logic [REGISTER_SIZE-1:0] block_out,
    output logic                     loaded_out
);

    localparam int               IDX_W    = block_idx_w(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [REGISTER_SIZE-1:0] mem_r [NUM_BLOCKS];
    logic [IDX_W-1:0]         wr_idx_r;
    logic [IDX_W-1:0]         rd_idx_r;
    logic                     loaded_r;

    // Block storage; contents deliberately survive reset, only the flags are cleared.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_r[wr_idx_r] <= wr_data;
        end
    end

    // Host write pointer and loaded flag; the first block of any reload invalidates the constant.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_idx_r <= ZERO_IDX;
            loaded_r <= 1'b0;
        end else if (wr_en) begin
            if (wr_idx_r == LAST_IDX) begin
                wr_idx_r <= ZERO_IDX;
                loaded_r <= 1'b1;
            end else begin
                wr_idx_r <= wr_idx_r + ONE_IDX;
                if (wr_idx_r == ZERO_IDX) begin
                    loaded_r <= 1'b0;
                end else begin
                    loaded_r <= loaded_r;
                end
            end
        end else begin
            wr_idx_r <= wr_idx_r;
            loaded_r <= loaded_r;
        end
    end

    // Reader index: rewind beats consume; wrap lets N be walked several times per reduction.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_idx_r <= ZERO_IDX;
        end else if (rewind) begin
            rd_idx_r <= ZERO_IDX;
        end else if (consumed) begin
            if (rd_idx_r == LAST_IDX) begin
                rd_idx_r <= ZERO_IDX;
            end else begin
                rd_idx_r <= rd_idx_r + ONE_IDX;
            end
        end else begin
            rd_idx_r <= rd_idx_r;
        end
    end

    // Present the current block only once the whole constant is valid.
    always_comb begin
        block_out = {REGISTER_SIZE{1'b0}};
        if (loaded_r) begin
            block_out = mem_r[rd_idx_r];
        end else begin
            block_out = {REGISTER_SIZE{1'b0}};
        end
    end

    assign loaded_out = loaded_r;

endmodule : constant_block_channel

// File: rtl/montgomery_constant_feeder.sv
// Feeds k = -N^-1 mod R and N block by block into the Montgomery reducer.
module montgomery_constant_feeder
    import montgomery_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     load_valid_in,
    input  logic                     load_sel_in,
    input  logic [REGISTER_SIZE-1:0] load_block_in,
    input  logic                     rewind_in,
    input  logic                     consumed_k_in,
    input  logic                     consumed_N_in,
    output logic [REGISTER_SIZE-1:0] k_constant_block_out,
    output logic [REGISTER_SIZE-1:0] modN_constant_block_out,
    output logic                     constants_ready_out
);

    const_sel_t load_sel_s;
    logic       wr_k_s;
    logic       wr_n_s;
    logic       loaded_k_s;
    logic       loaded_n_s;

    // Route a host write to exactly one channel.
    always_comb begin
        load_sel_s = const_sel_t'(load_sel_in);
        wr_k_s     = 1'b0;
        wr_n_s     = 1'b0;
        if (load_valid_in) begin
            case (load_sel_s)
                CONST_K: wr_k_s = 1'b1;
                CONST_N: wr_n_s = 1'b1;
                default: begin
                    wr_k_s = 1'b0;
                    wr_n_s = 1'b0;
                end
            endcase
        end else begin
            wr_k_s = 1'b0;
            wr_n_s = 1'b0;
        end
    end

    constant_block_channel #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .NUM_BLOCKS    (NUM_BLOCKS)
    ) u_k_channel (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_en      (wr_k_s),
        .wr_data    (load_block_in),
        .rewind     (rewind_in),
        .consumed   (consumed_k_in),
        .block_out  (k_constant_block_out),
        .loaded_out (loaded_k_s)
    );

    constant_block_channel #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .NUM_BLOCKS    (NUM_BLOCKS)
    ) u_n_channel (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_en      (wr_n_s),
        .wr_data    (load_block_in),
        .rewind     (rewind_in),
        .consumed   (consumed_N_in),
        .block_out  (modN_constant_block_out),
        .loaded_out (loaded_n_s)
    );

    assign constants_ready_out = loaded_k_s & loaded_n_s;

endmodule : montgomery_constant_feeder

// File: tb/tb_montgomery_constant_feeder.sv
// Directed + random bench for montgomery_constant_feeder against a plain array model.
module tb_montgomery_constant_feeder;

    localparam int RS = 32;
    localparam int NB = 128;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          load_valid_in;
    logic          load_sel_in;
    logic [RS-1:0] load_block_in;
    logic          rewind_in;
    logic          consumed_k_in;
    logic          consumed_N_in;
    logic [RS-1:0] k_constant_block_out;
    logic [RS-1:0] modN_constant_block_out;
    logic          constants_ready_out;

    montgomery_constant_feeder #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB)) dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .load_valid_in           (load_valid_in),
        .load_sel_in             (load_sel_in),
        .load_block_in           (load_block_in),
        .rewind_in               (rewind_in),
        .consumed_k_in           (consumed_k_in),
        .consumed_N_in           (consumed_N_in),
        .k_constant_block_out    (k_constant_block_out),
        .modN_constant_block_out (modN_constant_block_out),
        .constants_ready_out     (constants_ready_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: index 0 = k, 1 = N.
    logic [RS-1:0] m_mem [2][NB];
    int            m_wr [2];
    int            m_rd [2];
    bit            m_loaded [2];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [RS-1:0] exp_block(input int ch);
        return m_loaded[ch] ? m_mem[ch][m_rd[ch]] : '0;
    endfunction

    task automatic check32(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock: apply inputs, advance the model by the behavioural rules, compare all outputs.
    task automatic step(input string tag, input bit rst, input bit lv, input bit sel,
                        input logic [RS-1:0] data, input bit rew, input bit ck, input bit cn);
        bit cons [2];
        rst_in = rst; load_valid_in = lv; load_sel_in = sel; load_block_in = data;
        rewind_in = rew; consumed_k_in = ck; consumed_N_in = cn;
        @(posedge clk_in);
        #1;
        cons[0] = ck;
        cons[1] = cn;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_wr[c] = 0; m_rd[c] = 0; m_loaded[c] = 0;
            end
        end else begin
            if (lv) begin
                int c;
                c = sel ? 1 : 0;
                m_mem[c][m_wr[c]] = data;
                if (m_wr[c] == 0) m_loaded[c] = 0;
                if (m_wr[c] == NB - 1) begin
                    m_loaded[c] = 1;
                    m_wr[c] = 0;
                end else begin
                    m_wr[c] = m_wr[c] + 1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (rew) m_rd[c] = 0;
                else if (cons[c]) m_rd[c] = (m_rd[c] + 1) % NB;
            end
        end
        check32({tag, ".k"}, k_constant_block_out, exp_block(0));
        check32({tag, ".n"}, modN_constant_block_out, exp_block(1));
        check1({tag, ".ready"}, constants_ready_out, m_loaded[0] && m_loaded[1]);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        logic [RS-1:0] first_word;

        // Reset state.
        step("reset", 1, 0, 0, '0, 0, 0, 0);
        step("reset", 1, 0, 0, '0, 0, 0, 0);
        check32("reset_k_zero", k_constant_block_out, 32'h0);
        check1("reset_ready_low", constants_ready_out, 1'b0);

        // Interleaved load of k = 0x100+i and N = 0x200+i.
        for (int i = 0; i < NB; i++) begin
            step("load_k", 0, 1, 0, 32'h100 + RS'(i), 0, 0, 0);
            if (i == NB - 1) check1("ready_before_last_n", constants_ready_out, 1'b0);
            step("load_n", 0, 1, 1, 32'h200 + RS'(i), 0, 0, 0);
        end
        check1("ready_after_last_n", constants_ready_out, 1'b1);
        check32("k_block0", k_constant_block_out, 32'h100);
        check32("n_block0", modN_constant_block_out, 32'h200);

        // Five consecutive k consumes.
        for (int i = 1; i <= 5; i++) begin
            step("cons_k", 0, 0, 0, '0, 0, 1, 0);
            check32("k_advance", k_constant_block_out, 32'h100 + RS'(i));
            check32("n_hold", modN_constant_block_out, 32'h200);
        end
        idle("idle1");

        // Full N traversal with wrap.
        for (int i = 1; i <= NB; i++) begin
            step("cons_n", 0, 0, 0, '0, 0, 0, 1);
        end
        check32("n_wrapped", modN_constant_block_out, 32'h200);

        // Rewind beats a simultaneous consume at index 40.
        for (int i = 0; i < 40; i++) step("to40", 0, 0, 0, '0, 0, 0, 1);
        check32("n_at40", modN_constant_block_out, 32'h228);
        step("rew_cons", 0, 0, 0, '0, 1, 1, 1);
        check32("rewind_wins_n", modN_constant_block_out, 32'h200);
        check32("rewind_wins_k", k_constant_block_out, 32'h100);
        step("rew_hold", 0, 0, 0, '0, 1, 0, 0);
        step("rew_hold", 0, 0, 0, '0, 1, 0, 0);

        // Reload k starting with 0xDEAD.
        step("reload0", 0, 1, 0, 32'hDEAD, 0, 0, 0);
        check1("reload_ready_drop", constants_ready_out, 1'b0);
        check32("reload_k_zero", k_constant_block_out, 32'h0);
        for (int i = 1; i < NB; i++) step("reload", 0, 1, 0, $urandom, 0, 0, 0);
        step("reload_rew", 0, 0, 0, '0, 1, 0, 0);
        check1("reload_ready_back", constants_ready_out, 1'b1);
        check32("reload_k_dead", k_constant_block_out, 32'hDEAD);

        // Reset in the middle of a load.
        for (int i = 0; i < 60; i++) step("partial", 0, 1, 0, $urandom, 0, 0, 0);
        step("mid_reset", 1, 0, 0, '0, 0, 0, 0);
        first_word = $urandom;
        step("fresh_k", 0, 1, 0, first_word, 0, 0, 0);
        for (int i = 1; i < NB; i++) step("fresh_k", 0, 1, 0, $urandom, 0, 0, 0);
        check1("fresh_k_only_not_ready", constants_ready_out, 1'b0);
        for (int i = 0; i < NB; i++) step("fresh_n", 0, 1, 1, $urandom, 0, 0, 0);
        check1("fresh_ready", constants_ready_out, 1'b1);
        check32("fresh_block0", k_constant_block_out, first_word);

        // Random traffic: consumes, rewinds and occasional writes.
        for (int i = 0; i < 600; i++) begin
            step("random", 0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom,
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_montgomery_constant_feeder
